// File: rtl/gp9001_host_if.sv
// gp9001_host_if
// Slave side of the 68k -> GP9001 op handshake. It services the CPU glue's
// level-held op strobes: register select and write, VRAM pointer load, and
// VRAM read/write with pointer auto-increment. It arbitrates the VRAM port
// against the renderer.
//
// Ports
//   CLK96, RESET96_N             clock, async active-low reset
//   OP_*                         level op requests from the CPU glue
//   DIN, UDSn, LDSn              CPU write data and byte strobes (active low)
//   GP9001_ACK, GP9001_DOUT      op complete, read data
//   VRAM_BUSY                    renderer owns the VRAM port this cycle
//   VRAM_ADDR/WE/D/RD, VRAM_Q    VRAM port (registered requests)
//   REG_WE, REG_IDX, REG_DATA    register write strobe, index and data
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for an op; highest-priority op is taken
// BUS_WAIT | RAM op pending; waiting for the renderer to release VRAM
// RD_WAIT  | read issued; counting out VRAM read latency
// DONE     | ACK high; held until every OP_* is low
module gp9001_host_if #(
  parameter int VRAM_AW = 14,
  parameter int RD_LAT  = 2,
  parameter int NREG_W  = 8
) (
  input  logic               CLK96,
  input  logic               RESET96_N,
  input  logic               OP_SELECT_REG,
  input  logic               OP_WRITE_REG,
  input  logic               OP_WRITE_RAM,
  input  logic               OP_READ_RAM_H,
  input  logic               OP_READ_RAM_L,
  input  logic               OP_SET_RAM_PTR,
  input  logic [15:0]        DIN,
  input  logic               UDSn,
  input  logic               LDSn,
  output logic               GP9001_ACK,
  output logic [15:0]        GP9001_DOUT,
  input  logic               VRAM_BUSY,
  output logic [VRAM_AW-1:0] VRAM_ADDR,
  output logic [1:0]         VRAM_WE,
  output logic [15:0]        VRAM_D,
  output logic               VRAM_RD,
  input  logic [15:0]        VRAM_Q,
  output logic               REG_WE,
  output logic [NREG_W-1:0]  REG_IDX,
  output logic [15:0]        REG_DATA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS_WAIT,
    S_RD_WAIT,
    S_DONE
  } state_t;

  // VRAM_Q is sampled on the RD_LAT-th rising edge after the edge that
  // raised VRAM_RD; the counter is preloaded so it hits zero on that edge.
  localparam logic [2:0]         RD_CNT_INIT = 3'(RD_LAT - 1);
  localparam logic [VRAM_AW-1:0] PTR_ONE     = VRAM_AW'(1);

  state_t               state_q, state_d;
  logic                 is_rd_q, is_rd_d;
  logic [VRAM_AW-1:0]   ptr_q, ptr_d;
  logic [VRAM_AW-1:0]   addr_q, addr_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [15:0]          dout_q, dout_d;
  logic [15:0]          vd_q, vd_d;
  logic [15:0]          rdata_q, rdata_d;
  logic [NREG_W-1:0]    idx_q, idx_d;
  logic [1:0]           we_q, we_d;
  logic                 rd_q, rd_d;
  logic                 regwe_q, regwe_d;
  logic                 any_op;

  assign any_op = OP_SELECT_REG | OP_WRITE_REG | OP_WRITE_RAM |
                  OP_READ_RAM_H | OP_READ_RAM_L | OP_SET_RAM_PTR;

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q <= S_IDLE;
      is_rd_q <= 1'b0;
      ptr_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vd_q    <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      we_q    <= '0;
      rd_q    <= 1'b0;
      regwe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vd_q    <= vd_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      regwe_q <= regwe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vd_d    = vd_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    we_d    = 2'b00;
    rd_d    = 1'b0;
    regwe_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (OP_SET_RAM_PTR) begin
          ptr_d   = DIN[VRAM_AW-1:0];
          state_d = S_DONE;
        end else if (OP_SELECT_REG) begin
          idx_d   = DIN[NREG_W-1:0];
          state_d = S_DONE;
        end else if (OP_WRITE_REG) begin
          rdata_d = DIN;
          regwe_d = 1'b1;
          state_d = S_DONE;
        end else if (OP_WRITE_RAM) begin
          is_rd_d = 1'b0;
          state_d = S_BUS_WAIT;
        end else if (OP_READ_RAM_H || OP_READ_RAM_L) begin
          is_rd_d = 1'b1;
          state_d = S_BUS_WAIT;
        end
      end

      S_BUS_WAIT: begin
        if (!VRAM_BUSY) begin
          // Address is the pre-increment pointer; the pointer bumps even
          // when both byte strobes are inactive.
          addr_d = ptr_q;
          ptr_d  = ptr_q + PTR_ONE;
          if (is_rd_q) begin
            rd_d    = 1'b1;
            cnt_d   = RD_CNT_INIT;
            state_d = S_RD_WAIT;
          end else begin
            we_d    = {~UDSn, ~LDSn};
            vd_d    = DIN;
            state_d = S_DONE;
          end
        end
      end

      S_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          dout_d  = VRAM_Q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_DONE: begin
        if (!any_op) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign GP9001_ACK  = (state_q == S_DONE);
  assign GP9001_DOUT = dout_q;
  assign VRAM_ADDR   = addr_q;
  assign VRAM_WE     = we_q;
  assign VRAM_D      = vd_q;
  assign VRAM_RD     = rd_q;
  assign REG_WE      = regwe_q;
  assign REG_IDX     = idx_q;
  assign REG_DATA    = rdata_q;

endmodule

// File: tb/tb_gp9001_host_if.sv
module tb_gp9001_host_if;

  logic        CLK96;
  logic        RESET96_N;
  logic        OP_SELECT_REG, OP_WRITE_REG, OP_WRITE_RAM;
  logic        OP_READ_RAM_H, OP_READ_RAM_L, OP_SET_RAM_PTR;
  logic [15:0] DIN;
  logic        UDSn, LDSn;
  logic        GP9001_ACK;
  logic [15:0] GP9001_DOUT;
  logic        VRAM_BUSY;
  logic [13:0] VRAM_ADDR;
  logic [1:0]  VRAM_WE;
  logic [15:0] VRAM_D;
  logic        VRAM_RD;
  logic [15:0] VRAM_Q;
  logic        REG_WE;
  logic [7:0]  REG_IDX;
  logic [15:0] REG_DATA;

  int checks = 0;
  int errors = 0;

  gp9001_host_if #(.VRAM_AW(14), .RD_LAT(2), .NREG_W(8)) dut (
    .CLK96(CLK96), .RESET96_N(RESET96_N),
    .OP_SELECT_REG(OP_SELECT_REG), .OP_WRITE_REG(OP_WRITE_REG),
    .OP_WRITE_RAM(OP_WRITE_RAM), .OP_READ_RAM_H(OP_READ_RAM_H),
    .OP_READ_RAM_L(OP_READ_RAM_L), .OP_SET_RAM_PTR(OP_SET_RAM_PTR),
    .DIN(DIN), .UDSn(UDSn), .LDSn(LDSn),
    .GP9001_ACK(GP9001_ACK), .GP9001_DOUT(GP9001_DOUT),
    .VRAM_BUSY(VRAM_BUSY), .VRAM_ADDR(VRAM_ADDR), .VRAM_WE(VRAM_WE),
    .VRAM_D(VRAM_D), .VRAM_RD(VRAM_RD), .VRAM_Q(VRAM_Q),
    .REG_WE(REG_WE), .REG_IDX(REG_IDX), .REG_DATA(REG_DATA)
  );

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  task automatic tick();
    @(posedge CLK96);
    #1;
  endtask

  task automatic clear_ops();
    OP_SELECT_REG = 0; OP_WRITE_REG = 0; OP_WRITE_RAM = 0;
    OP_READ_RAM_H = 0; OP_READ_RAM_L = 0; OP_SET_RAM_PTR = 0;
  endtask

  task automatic test_reset();
    RESET96_N = 0; clear_ops(); DIN = 0; UDSn = 1; LDSn = 1;
    VRAM_BUSY = 0; VRAM_Q = 16'h0000;
    #3;
    checks++; if (GP9001_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", GP9001_ACK); end
    checks++; if (GP9001_DOUT !== 16'h0) begin errors++; $display("FAIL reset_dout got %h want 0000", GP9001_DOUT); end
    checks++; if ({VRAM_WE, VRAM_RD, REG_WE} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000", {VRAM_WE, VRAM_RD, REG_WE}); end
    checks++; if ({REG_IDX, REG_DATA, VRAM_D} !== 40'h0) begin errors++; $display("FAIL reset_regs got %h want 0", {REG_IDX, REG_DATA, VRAM_D}); end
    tick(); tick();
    RESET96_N = 1;
    tick();
    // move ptr away from zero, then start a read and reset it mid-flight
    OP_SET_RAM_PTR = 1; DIN = 16'h0055;
    tick();
    clear_ops(); tick();
    OP_READ_RAM_H = 1;
    tick(); tick();
    checks++; if (VRAM_RD !== 1'b1 || VRAM_ADDR !== 14'h0055) begin errors++; $display("FAIL midread_issue got rd=%b addr=%h want rd=1 addr=0055", VRAM_RD, VRAM_ADDR); end
    RESET96_N = 0;
    #1;
    checks++; if (GP9001_ACK !== 1'b0 || VRAM_RD !== 1'b0) begin errors++; $display("FAIL midread_reset got ack=%b rd=%b want 0 0", GP9001_ACK, VRAM_RD); end
    clear_ops();
    tick();
    RESET96_N = 1;
    tick();
    // ptr must be zero again: a write lands at address 0
    OP_WRITE_RAM = 1; DIN = 16'h0001; UDSn = 0; LDSn = 0;
    tick(); tick();
    checks++; if (VRAM_WE !== 2'b11 || VRAM_ADDR !== 14'h0000 || GP9001_ACK !== 1'b1) begin errors++; $display("FAIL reset_ptr got we=%b addr=%h ack=%b want 11 0000 1", VRAM_WE, VRAM_ADDR, GP9001_ACK); end
    clear_ops(); tick();
  endtask

  task automatic test_set_ptr();
    OP_SET_RAM_PTR = 1; DIN = 16'h1234;
    tick();
    checks++; if (GP9001_ACK !== 1'b1) begin errors++; $display("FAIL setptr_ack got %b want 1", GP9001_ACK); end
    tick();
    checks++; if (GP9001_ACK !== 1'b1) begin errors++; $display("FAIL setptr_hold got %b want 1", GP9001_ACK); end
    clear_ops();
    tick();
    checks++; if (GP9001_ACK !== 1'b0) begin errors++; $display("FAIL setptr_drop got %b want 0", GP9001_ACK); end
    OP_WRITE_RAM = 1; DIN = 16'h7777; UDSn = 0; LDSn = 0;
    tick(); tick();
    checks++; if (VRAM_ADDR !== 14'h1234) begin errors++; $display("FAIL setptr_addr got %h want 1234", VRAM_ADDR); end
    clear_ops(); tick();
  endtask

  task automatic test_write_wrap();
    OP_SET_RAM_PTR = 1; DIN = 16'h3FFF;
    tick(); clear_ops(); tick();
    OP_WRITE_RAM = 1; DIN = 16'hBEEF; UDSn = 0; LDSn = 0;
    tick();
    checks++; if (VRAM_WE !== 2'b00 || GP9001_ACK !== 1'b0) begin errors++; $display("FAIL wr_early got we=%b ack=%b want 00 0", VRAM_WE, GP9001_ACK); end
    tick();
    checks++; if (VRAM_WE !== 2'b11 || VRAM_ADDR !== 14'h3FFF || VRAM_D !== 16'hBEEF || GP9001_ACK !== 1'b1) begin errors++; $display("FAIL wr_top got we=%b addr=%h d=%h ack=%b want 11 3fff beef 1", VRAM_WE, VRAM_ADDR, VRAM_D, GP9001_ACK); end
    clear_ops();
    tick();
    checks++; if (VRAM_WE !== 2'b00 || GP9001_ACK !== 1'b0) begin errors++; $display("FAIL wr_pulse got we=%b ack=%b want 00 0", VRAM_WE, GP9001_ACK); end
    OP_WRITE_RAM = 1; DIN = 16'h1200; UDSn = 0; LDSn = 1;
    tick(); tick();
    checks++; if (VRAM_WE !== 2'b10 || VRAM_ADDR !== 14'h0000) begin errors++; $display("FAIL wr_wrap got we=%b addr=%h want 10 0000", VRAM_WE, VRAM_ADDR); end
    clear_ops(); tick();
    OP_WRITE_RAM = 1; DIN = 16'h3333; UDSn = 1; LDSn = 1;
    tick(); tick();
    checks++; if (VRAM_WE !== 2'b00 || VRAM_ADDR !== 14'h0001 || GP9001_ACK !== 1'b1) begin errors++; $display("FAIL wr_nostrobe got we=%b addr=%h ack=%b want 00 0001 1", VRAM_WE, VRAM_ADDR, GP9001_ACK); end
    clear_ops(); tick();
  endtask

  // ptr is 2 here; VRAM_Q carries the data only in the cycle before the
  // capture edge, so an early or late capture is seen
  task automatic test_read();
    OP_READ_RAM_L = 1; VRAM_Q = 16'h0000;
    tick();
    checks++; if (VRAM_RD !== 1'b0 || GP9001_ACK !== 1'b0) begin errors++; $display("FAIL rd_c1 got rd=%b ack=%b want 0 0", VRAM_RD, GP9001_ACK); end
    tick();
    checks++; if (VRAM_RD !== 1'b1 || VRAM_ADDR !== 14'h0002 || GP9001_ACK !== 1'b0) begin errors++; $display("FAIL rd_c2 got rd=%b addr=%h ack=%b want 1 0002 0", VRAM_RD, VRAM_ADDR, GP9001_ACK); end
    tick();
    checks++; if (VRAM_RD !== 1'b0 || GP9001_ACK !== 1'b0) begin errors++; $display("FAIL rd_c3 got rd=%b ack=%b want 0 0", VRAM_RD, GP9001_ACK); end
    VRAM_Q = 16'hA5A5;
    tick();
    VRAM_Q = 16'hFFFF;
    checks++; if (GP9001_ACK !== 1'b1 || GP9001_DOUT !== 16'hA5A5) begin errors++; $display("FAIL rd_c4 got ack=%b dout=%h want 1 a5a5", GP9001_ACK, GP9001_DOUT); end
    clear_ops(); tick();
    checks++; if (GP9001_ACK !== 1'b0 || GP9001_DOUT !== 16'hA5A5) begin errors++; $display("FAIL rd_hold got ack=%b dout=%h want 0 a5a5", GP9001_ACK, GP9001_DOUT); end
  endtask

  // ptr is 3 here (read advanced it)
  task automatic test_busy_write();
    OP_WRITE_RAM = 1; DIN = 16'h5A5A; UDSn = 1; LDSn = 0;
    tick();
    VRAM_BUSY = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (VRAM_WE !== 2'b00 || GP9001_ACK !== 1'b0) begin errors++; $display("FAIL busy_stall%0d got we=%b ack=%b want 00 0", i, VRAM_WE, GP9001_ACK); end
    end
    VRAM_BUSY = 0;
    tick();
    checks++; if (VRAM_WE !== 2'b01 || VRAM_ADDR !== 14'h0003 || VRAM_D !== 16'h5A5A || GP9001_ACK !== 1'b1) begin errors++; $display("FAIL busy_issue got we=%b addr=%h d=%h ack=%b want 01 0003 5a5a 1", VRAM_WE, VRAM_ADDR, VRAM_D, GP9001_ACK); end
    clear_ops(); tick();
  endtask

  task automatic test_regs();
    OP_SELECT_REG = 1; DIN = 16'h000F;
    tick();
    checks++; if (GP9001_ACK !== 1'b1 || REG_IDX !== 8'h0F || REG_WE !== 1'b0) begin errors++; $display("FAIL sel got ack=%b idx=%h we=%b want 1 0f 0", GP9001_ACK, REG_IDX, REG_WE); end
    clear_ops(); tick();
    OP_WRITE_REG = 1; DIN = 16'h00C0;
    tick();
    checks++; if (REG_WE !== 1'b1 || REG_IDX !== 8'h0F || REG_DATA !== 16'h00C0 || GP9001_ACK !== 1'b1) begin errors++; $display("FAIL wreg got we=%b idx=%h data=%h ack=%b want 1 0f 00c0 1", REG_WE, REG_IDX, REG_DATA, GP9001_ACK); end
    tick();
    checks++; if (REG_WE !== 1'b0 || GP9001_ACK !== 1'b1) begin errors++; $display("FAIL wreg_pulse got we=%b ack=%b want 0 1", REG_WE, GP9001_ACK); end
    clear_ops(); tick();
    checks++; if (REG_WE !== 1'b0 || REG_DATA !== 16'h00C0 || GP9001_ACK !== 1'b0) begin errors++; $display("FAIL wreg_end got we=%b data=%h ack=%b want 0 00c0 0", REG_WE, REG_DATA, GP9001_ACK); end
  endtask

  // SET_RAM_PTR outranks WRITE_REG; while ACK is up nothing else is taken
  task automatic test_priority();
    OP_SET_RAM_PTR = 1; OP_WRITE_REG = 1; DIN = 16'h0100;
    tick();
    checks++; if (GP9001_ACK !== 1'b1 || REG_WE !== 1'b0) begin errors++; $display("FAIL prio_first got ack=%b we=%b want 1 0", GP9001_ACK, REG_WE); end
    tick(); tick();
    checks++; if (REG_WE !== 1'b0 || REG_DATA !== 16'h00C0) begin errors++; $display("FAIL prio_noaccept got we=%b data=%h want 0 00c0", REG_WE, REG_DATA); end
    clear_ops(); tick();
    OP_WRITE_RAM = 1; DIN = 16'h4444; UDSn = 0; LDSn = 0;
    tick(); tick();
    checks++; if (VRAM_ADDR !== 14'h0100 || VRAM_WE !== 2'b11) begin errors++; $display("FAIL prio_ptr got addr=%h we=%b want 0100 11", VRAM_ADDR, VRAM_WE); end
    clear_ops(); tick();
  endtask

  initial begin
    test_reset();
    test_set_ptr();
    test_write_wrap();
    test_read();
    test_busy_write();
    test_regs();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
